icache_dm_resp: RTL and testbench

- Direct-mapped, blocking L1 instruction cache. Acts as the responder on the fetch-to-I-cache protocol and replaces the fixed instruction ROM used in fetch/decode bring-up.
- Serves 1-cycle hits to the fetch stage. On a miss, refills a full line from a simple burst memory port, then replays the pending request.
- Sits between fetch_top and the L2/memory model.

---
 rtl/icache_dm_resp_pkg.sv | 34 +++
 rtl/icache_dm_resp_if.sv | 32 +++
 rtl/icache_dm_array.sv | 66 ++++++
 rtl/icache_dm_resp.sv | 131 +++++++++++++
 tb/tb_icache_dm_resp.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_dm_resp_pkg.sv
// Shared definitions for the direct-mapped L1 instruction cache.
package icache_dm_resp_pkg;

    localparam int unsigned IC_ADDR = 32;
    localparam int unsigned IC_INST = 32;

    // Controller state encoding
    typedef logic [2:0] IcState_t;
    localparam IcState_t IC_IDLE   = 3'd0;
    localparam IcState_t IC_LOOKUP = 3'd1;
    localparam IcState_t IC_REQ    = 3'd2;
    localparam IcState_t IC_FILL   = 3'd3;
    localparam IcState_t IC_REPLAY = 3'd4;

    // Address field widths
    function automatic int unsigned ofs_w(input int unsigned line);
        return $clog2(line);
    endfunction

    function automatic int unsigned idx_w(input int unsigned cache, input int unsigned line);
        return $clog2(cache / line);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr, input int unsigned cache);
        return addr - $clog2(cache);
    endfunction

    // One fetch response
    typedef struct packed {
        logic [IC_ADDR-1:0] pc;
        logic [IC_INST-1:0] inst;
    } ic_resp_t;

endpackage

// File: rtl/icache_dm_resp_if.sv
// Fetch-side and refill-side signals of the instruction cache.
interface icache_dm_resp_if #(
    parameter int unsigned ADDR = 32,
    parameter int unsigned INST = 32
) ();
    logic            fetch_req;
    logic [ADDR-1:0] fetch_pc;
    logic            fetch_flush;
    logic            ic_ready;
    logic            ic_valid;
    logic [ADDR-1:0] ic_pc;
    logic [INST-1:0] ic_inst;
    logic            ic_miss;
    logic            ic_inval;
    logic            mem_req;
    logic [ADDR-1:0] mem_addr;
    logic            mem_ack;
    logic            mem_rvalid;
    logic [INST-1:0] mem_rdata;

    // Cache side
    modport slave (
        input  fetch_req, fetch_pc, fetch_flush, ic_inval, mem_ack, mem_rvalid, mem_rdata,
        output ic_ready, ic_valid, ic_pc, ic_inst, ic_miss, mem_req, mem_addr
    );

    // Fetch stage / memory side
    modport master (
        output fetch_req, fetch_pc, fetch_flush, ic_inval, mem_ack, mem_rvalid, mem_rdata,
        input  ic_ready, ic_valid, ic_pc, ic_inst, ic_miss, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_dm_array.sv
// Data, tag and valid storage with one synchronous read port.
module icache_dm_array import icache_dm_resp_pkg::*; #(
    parameter int unsigned INST  = IC_INST,
    parameter int unsigned SETS  = 256,
    parameter int unsigned WORDS = 4,
    parameter int unsigned TAG   = 20
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     rd_en,
    input  logic [$clog2(SETS)-1:0]  rd_idx,
    input  logic [$clog2(WORDS)-1:0] rd_word,
    output logic [INST-1:0]          rd_data,
    output logic [TAG-1:0]           rd_tag,
    output logic                     rd_valid,
    input  logic                     wr_en,
    input  logic [$clog2(SETS)-1:0]  wr_idx,
    input  logic [$clog2(WORDS)-1:0] wr_word,
    input  logic [INST-1:0]          wr_data,
    input  logic                     tag_we,
    input  logic [TAG-1:0]           tag_wdata,
    input  logic                     clr_all
);
    localparam int unsigned IDX  = $clog2(SETS);
    localparam int unsigned WSEL = $clog2(WORDS);

    logic [INST-1:0]      data_mem [SETS*WORDS];
    logic [TAG-1:0]       tag_mem  [SETS];
    logic [SETS-1:0]      valid;
    logic [IDX+WSEL-1:0]  rd_addr;
    logic [IDX+WSEL-1:0]  wr_addr;

    assign rd_addr = {rd_idx, rd_word};
    assign wr_addr = {wr_idx, wr_word};

    // Refill word write
    always_ff @(posedge clk) begin
        if (wr_en) data_mem[wr_addr] <= wr_data;
    end

    // Tag install on the last refill beat
    always_ff @(posedge clk) begin
        if (tag_we) tag_mem[wr_idx] <= tag_wdata;
    end

    // Valid bits: cleared by reset or invalidate-all, set on tag install
    always_ff @(posedge clk) begin
        if (!reset_)      valid <= '0;
        else if (clr_all) valid <= '0;
        else if (tag_we)  valid[wr_idx] <= 1'b1;
    end

    // Synchronous read; the replay read is issued in the same cycle as the
    // last refill write, so a same-address write is forwarded
    always_ff @(posedge clk) begin
        if (!reset_) begin
            rd_data  <= '0;
            rd_tag   <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= (wr_en && (wr_addr == rd_addr)) ? wr_data : data_mem[rd_addr];
            rd_tag   <= tag_mem[rd_idx];
            rd_valid <= valid[rd_idx];
        end
    end
endmodule

// File: rtl/icache_dm_resp.sv
// Direct-mapped blocking L1 instruction cache: 1-cycle hits, line refill on miss.
module icache_dm_resp import icache_dm_resp_pkg::*; #(
    parameter int unsigned ADDR     = IC_ADDR,
    parameter int unsigned INST     = IC_INST,
    parameter int unsigned L1_CACHE = 4096,
    parameter int unsigned LINE     = 16
) (
    input  logic            clk,
    input  logic            reset_,
    icache_dm_resp_if.slave bus
);
    localparam int unsigned WORDS = LINE / (INST / 8);
    localparam int unsigned SETS  = L1_CACHE / LINE;
    localparam int unsigned OFS   = ofs_w(LINE);
    localparam int unsigned IDX   = idx_w(L1_CACHE, LINE);
    localparam int unsigned TAG   = tag_w(ADDR, L1_CACHE);
    localparam int unsigned WB    = $clog2(INST / 8);
    localparam int unsigned WSEL  = $clog2(WORDS);
    localparam logic [WSEL-1:0] LAST_BEAT = WSEL'(WORDS - 1);

    IcState_t        state;
    logic [ADDR-1:0] pc_q;
    logic [WSEL-1:0] beat;
    logic            cancel_q;
    logic            inval_pend;

    logic            rd_en;
    logic [IDX-1:0]  rd_idx;
    logic [WSEL-1:0] rd_word;
    logic [INST-1:0] rd_data;
    logic [TAG-1:0]  rd_tag;
    logic            rd_valid;

    logic hit, lookup_hit, inval_now, accept, fill_we, fill_last;

    assign hit        = rd_valid && (rd_tag == pc_q[ADDR-1 -: TAG]);
    assign lookup_hit = (state == IC_LOOKUP) && hit;
    assign inval_now  = (bus.ic_inval || inval_pend) && ((state == IC_IDLE) || lookup_hit);
    assign accept     = bus.fetch_req && bus.ic_ready;
    assign fill_we    = (state == IC_FILL) && bus.mem_rvalid;
    assign fill_last  = fill_we && (beat == LAST_BEAT);

    assign bus.ic_ready = ((state == IC_IDLE) || lookup_hit) && !inval_now;
    assign bus.ic_valid = !bus.fetch_flush &&
                          (lookup_hit || ((state == IC_REPLAY) && !cancel_q));
    assign bus.ic_pc    = pc_q;
    assign bus.ic_inst  = rd_data;
    assign bus.ic_miss  = ((state == IC_LOOKUP) && !hit) || (state == IC_REQ) ||
                          (state == IC_FILL) || (state == IC_REPLAY);
    assign bus.mem_req  = (state == IC_REQ);
    assign bus.mem_addr = {pc_q[ADDR-1:OFS], {OFS{1'b0}}};

    // Read port: new request address, or the pending pc for the replay
    always_comb begin
        rd_en   = accept || fill_last;
        rd_idx  = pc_q[OFS +: IDX];
        rd_word = pc_q[WB +: WSEL];
        if (accept) begin
            rd_idx  = bus.fetch_pc[OFS +: IDX];
            rd_word = bus.fetch_pc[WB +: WSEL];
        end
    end

    // Controller FSM, refill beat counter, cancel and deferred invalidate
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state      <= IC_IDLE;
            pc_q       <= '0;
            beat       <= '0;
            cancel_q   <= 1'b0;
            inval_pend <= 1'b0;
        end else begin
            if (accept) pc_q <= bus.fetch_pc;
            if (inval_now)         inval_pend <= 1'b0;
            else if (bus.ic_inval) inval_pend <= 1'b1;
            case (state)
                IC_IDLE: if (accept) state <= IC_LOOKUP;
                IC_LOOKUP: begin
                    if (hit) begin
                        state <= accept ? IC_LOOKUP : IC_IDLE;
                    end else begin
                        state    <= IC_REQ;
                        cancel_q <= bus.fetch_flush;
                    end
                end
                IC_REQ: begin
                    if (bus.fetch_flush) cancel_q <= 1'b1;
                    if (bus.mem_ack)     state    <= IC_FILL;
                end
                IC_FILL: begin
                    if (bus.fetch_flush) cancel_q <= 1'b1;
                    if (fill_we) begin
                        beat <= beat + 1'b1;
                        if (fill_last) begin
                            beat  <= '0;
                            state <= IC_REPLAY;
                        end
                    end
                end
                IC_REPLAY: begin
                    state    <= IC_IDLE;
                    cancel_q <= 1'b0;
                end
                default: state <= IC_IDLE;
            endcase
        end
    end

    icache_dm_array #(
        .INST  (INST),
        .SETS  (SETS),
        .WORDS (WORDS),
        .TAG   (TAG)
    ) u_array (
        .clk       (clk),
        .reset_    (reset_),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_word   (rd_word),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .wr_en     (fill_we),
        .wr_idx    (pc_q[OFS +: IDX]),
        .wr_word   (beat),
        .wr_data   (bus.mem_rdata),
        .tag_we    (fill_last),
        .tag_wdata (pc_q[ADDR-1 -: TAG]),
        .clr_all   (inval_now)
    );
endmodule

// File: tb/tb_icache_dm_resp.sv
// Scoreboard bench for icache_dm_resp with a scripted burst memory.
module tb_icache_dm_resp;
    import icache_dm_resp_pkg::*;

    localparam int unsigned L1 = 4096;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    always #5 clk = ~clk;

    icache_dm_resp_if #(.ADDR(32), .INST(32)) bus ();

    icache_dm_resp #(
        .ADDR     (32),
        .INST     (32),
        .L1_CACHE (L1),
        .LINE     (16)
    ) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int v0;
    logic [31:0] p;
    ic_resp_t sb[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Backing memory contents: line 0x100 holds 0xA0..0xA3
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a >> 2) - 32'h40);
    endfunction

    task automatic push_exp(input logic [31:0] pc);
        ic_resp_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        sb.push_back(e);
    endtask

    // Response monitor
    always @(negedge clk) begin
        ic_resp_t e;
        if (reset_ && bus.ic_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                check_val("spurious_valid", bus.ic_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check_val("resp_pc", bus.ic_pc, e.pc);
                check_val("resp_inst", bus.ic_inst, e.inst);
            end
        end
    end

    task automatic check_reset_state();
        check_val("rst_valid", bus.ic_valid, 1'b0);
        check_val("rst_miss", bus.ic_miss, 1'b0);
        check_val("rst_mem_req", bus.mem_req, 1'b0);
        check_val("rst_ready", bus.ic_ready, 1'b1);
        check_val("rst_pc", bus.ic_pc, 32'h0);
        check_val("rst_inst", bus.ic_inst, 32'h0);
        check_val("rst_mem_addr", bus.mem_addr, 32'h0);
    endtask

    // Single request from IDLE; ends at the negedge of the LOOKUP cycle
    task automatic req_one(input logic [31:0] pc, input bit exp_hit, input bit exp_out);
        if (exp_out) push_exp(pc);
        @(posedge clk); #1;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        @(negedge clk);
        check_val("ready_at_req", bus.ic_ready, 1'b1);
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
        @(negedge clk);
        check_val("lookup_miss", bus.ic_miss, !exp_hit);
    endtask

    // Memory side of one refill; returns early if reset is applied mid-fill
    task automatic serve_refill(input logic [31:0] line, input int ack_delay, input int gap,
                                input int flush_beat, input int inval_beat, input int reset_after);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("mem_req_seen", bus.mem_req, 1'b1);
        check_val("mem_addr", bus.mem_addr, line);
        repeat (ack_delay) begin
            @(negedge clk);
            check_val("mem_req_hold", {bus.mem_req, bus.mem_addr}, {1'b1, line});
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (reset_after == b) begin
                bus.mem_rvalid = 1'b0;
                reset_ = 1'b0;
                @(posedge clk); #1;
                reset_ = 1'b1;
                return;
            end
            if (b > 0) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
            bus.mem_rvalid  = 1'b1;
            bus.mem_rdata   = mem_word(line + 32'(4 * b));
            bus.fetch_flush = (b == flush_beat);
            bus.ic_inval    = (b == inval_beat);
            @(negedge clk);
            if (b == 0) check_val("mem_req_drop", bus.mem_req, 1'b0);
            @(posedge clk); #1;
            bus.mem_rvalid  = 1'b0;
            bus.fetch_flush = 1'b0;
            bus.ic_inval    = 1'b0;
        end
    endtask

    task automatic finish_replay(input bit exp_valid, input bit exp_ready);
        @(negedge clk);
        check_val("replay_valid", bus.ic_valid, exp_valid);
        check_val("replay_miss", bus.ic_miss, 1'b1);
        @(negedge clk);
        check_val("miss_clear", bus.ic_miss, 1'b0);
        check_val("ready_after", bus.ic_ready, exp_ready);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        bus.fetch_req   = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_flush = 1'b0;
        bus.ic_inval    = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #1;
        reset_ = 1'b1;

        // Cold miss on 0x100
        req_one(32'h100, 1'b0, 1'b1);
        serve_refill(32'h100, 3, 0, -1, -1, -1);
        finish_replay(1'b1, 1'b1);

        // Back-to-back hits
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) begin
            p = 32'h104 + 32'(4 * i);
            push_exp(p);
            @(posedge clk); #1;
            bus.fetch_req = 1'b1;
            bus.fetch_pc  = p;
            @(negedge clk);
            check_val("stream_ready", bus.ic_ready, 1'b1);
            if (i > 0) check_val("stream_valid", bus.ic_valid, 1'b1);
        end
        @(posedge clk); #1;
        bus.fetch_req = 1'b0;
        @(negedge clk);
        check_val("stream_valid", bus.ic_valid, 1'b1);
        @(negedge clk);
        check_val("stream_count", valid_cnt - v0, 3);
        check_val("stream_idle", bus.ic_valid, 1'b0);

        // Flush in LOOKUP with a concurrent request
        @(posedge clk); #1;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'h104;
        @(posedge clk); #1;
        push_exp(32'h108);
        bus.fetch_flush = 1'b1;
        bus.fetch_pc    = 32'h108;
        @(negedge clk);
        check_val("lookup_flush_valid", bus.ic_valid, 1'b0);
        check_val("lookup_flush_ready", bus.ic_ready, 1'b1);
        @(posedge clk); #1;
        bus.fetch_req   = 1'b0;
        bus.fetch_flush = 1'b0;
        @(negedge clk);
        check_val("after_flush_valid", bus.ic_valid, 1'b1);

        // Conflict and eviction
        req_one(32'h100, 1'b1, 1'b1);
        req_one(32'h100 + L1, 1'b0, 1'b1);
        serve_refill(32'h100 + L1, 1, 1, -1, -1, -1);
        finish_replay(1'b1, 1'b1);
        req_one(32'h100, 1'b0, 1'b1);
        serve_refill(32'h100, 0, 0, -1, -1, -1);
        finish_replay(1'b1, 1'b1);

        // Flush during FILL
        req_one(32'h100 + L1, 1'b0, 1'b1);
        serve_refill(32'h100 + L1, 0, 0, -1, -1, -1);
        finish_replay(1'b1, 1'b1);
        req_one(32'h100, 1'b0, 1'b0);
        serve_refill(32'h100, 2, 0, 1, -1, -1);
        finish_replay(1'b0, 1'b1);
        req_one(32'h100, 1'b1, 1'b1);

        // Invalidate in IDLE wins over a concurrent request
        @(posedge clk); #1;
        bus.ic_inval  = 1'b1;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'h100;
        @(negedge clk);
        check_val("inval_ready", bus.ic_ready, 1'b0);
        @(posedge clk); #1;
        bus.ic_inval  = 1'b0;
        bus.fetch_req = 1'b0;
        @(negedge clk);
        check_val("inval_no_accept", bus.ic_miss, 1'b0);
        req_one(32'h100, 1'b0, 1'b1);
        // Invalidate during FILL takes effect after REPLAY
        serve_refill(32'h100, 0, 0, -1, 2, -1);
        finish_replay(1'b1, 1'b0);
        req_one(32'h100, 1'b0, 1'b1);
        serve_refill(32'h100, 0, 0, -1, -1, -1);
        finish_replay(1'b1, 1'b1);

        // Top set and its alias
        req_one(32'hFF0, 1'b0, 1'b1);
        serve_refill(32'hFF0, 1, 0, -1, -1, -1);
        finish_replay(1'b1, 1'b1);
        req_one(32'hFFC, 1'b1, 1'b1);
        req_one(32'hFF0 + L1, 1'b0, 1'b1);
        serve_refill(32'hFF0 + L1, 0, 2, -1, -1, -1);
        finish_replay(1'b1, 1'b1);

        // Reset after two refill beats
        req_one(32'h200, 1'b0, 1'b0);
        serve_refill(32'h200, 1, 0, -1, -1, 2);
        @(negedge clk);
        check_reset_state();
        v0 = valid_cnt;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        check_val("stray_no_valid", valid_cnt - v0, 0);
        check_val("stray_mem_req", bus.mem_req, 1'b0);
        check_val("stray_miss", bus.ic_miss, 1'b0);
        req_one(32'h100, 1'b0, 1'b1);
        serve_refill(32'h100, 0, 0, -1, -1, -1);
        finish_replay(1'b1, 1'b1);

        repeat (2) @(negedge clk);
        check_val("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
